// File: rtl/muldiv_unit_pkg.sv
// cpu_pkg: shared opcodes, state encoding and widths for the multiply/divide unit.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        FIX  = S_FIX,
        DONE = S_DONE
    } md_state_t;
    function automatic logic is_md_op(input logic [2:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
    endfunction
    function automatic logic [DATA_W-1:0] cond_neg(input logic n, input logic [DATA_W-1:0] v);
        return n ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage request and HI/LO/stall response bundle.
interface muldiv_unit_if
    import cpu_pkg::*;
();
    logic              startE;
    logic [2:0]        opE;
    logic [DATA_W-1:0] srcaE;
    logic [DATA_W-1:0] srcbE;
    logic              cancelE;
    logic              stall_mdE;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    modport master (
        output startE, opE, srcaE, srcbE, cancelE,
        input  stall_mdE, busy, hi, lo
    );
    modport slave (
        input  startE, opE, srcaE, srcbE, cancelE,
        output stall_mdE, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_iter.sv
// muldiv_iter: one radix-2 step, shift-add multiply or restoring shift-subtract divide.
module muldiv_iter
    import cpu_pkg::*;
(
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W-1:0]   opnd,
    input  logic                div,
    output logic [2*DATA_W-1:0] nxt
);
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   sr;
    logic              ge;
    logic [DATA_W-1:0] rem;
    always_comb begin
        sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, acc[0] ? opnd : {DATA_W{1'b0}}};
        // Remainder stays below the divisor, so only the shifted value needs the 33rd bit.
        sr  = acc[2*DATA_W-1:DATA_W-1];
        ge  = sr >= {1'b0, opnd};
        rem = sr[DATA_W-1:0] - opnd;
        nxt = div ? (ge ? {rem, acc[DATA_W-2:0], 1'b1} : {acc[2*DATA_W-2:0], 1'b0})
                  : {sum, acc[DATA_W-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO ownership and pipeline stall request.
module muldiv_unit
    import cpu_pkg::*;
(
    input logic         clk,
    input logic         rst,
    muldiv_unit_if.slave md
);
    md_state_t           state, state_n;
    logic [2*DATA_W-1:0] acc, acc_n, prod;
    logic [DATA_W-1:0]   opnd, a_raw, hi_n, lo_n;
    logic [CNT_W-1:0]    count;
    logic                div_q, neg_q, neg_r, div0, go, sgn, is_div, last, mt_ok;

    assign sgn    = md.opE == OP_MULT || md.opE == OP_DIV;
    assign is_div = md.opE == OP_DIV || md.opE == OP_DIVU;
    assign mt_ok  = state == IDLE && md.startE && !md.cancelE;
    assign go     = mt_ok && is_md_op(md.opE);
    assign last   = count == CNT_W'(DATA_W - 1);
    assign md.busy      = state == RUN || state == FIX;
    assign md.stall_mdE = go || md.busy;

    muldiv_iter u_iter (
        .acc  (acc),
        .opnd (opnd),
        .div  (div_q),
        .nxt  (acc_n)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? RUN : IDLE;
            RUN:     state_n = md.cancelE ? IDLE : (last ? FIX : RUN);
            FIX:     state_n = md.cancelE ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Divide by zero bypasses sign fixup: LO all ones, HI the untouched dividend.
    always_comb begin
        prod = neg_q ? -acc : acc;
        hi_n = div0 ? a_raw : (div_q ? cond_neg(neg_r, acc[2*DATA_W-1:DATA_W]) : prod[2*DATA_W-1:DATA_W]);
        lo_n = div0 ? {DATA_W{1'b1}} : (div_q ? cond_neg(neg_q, acc[DATA_W-1:0]) : prod[DATA_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            opnd  <= '0;
            a_raw <= '0;
            count <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            md.hi <= '0;
            md.lo <= '0;
        end else begin
            if (go) begin
                acc   <= {{DATA_W{1'b0}}, cond_neg(sgn & md.srcaE[DATA_W-1], md.srcaE)};
                opnd  <= cond_neg(sgn & md.srcbE[DATA_W-1], md.srcbE);
                a_raw <= md.srcaE;
                count <= '0;
                div_q <= is_div;
                neg_q <= sgn & (md.srcaE[DATA_W-1] ^ md.srcbE[DATA_W-1]);
                neg_r <= sgn & md.srcaE[DATA_W-1];
                div0  <= is_div && md.srcbE == '0;
            end
            if (state == RUN) begin
                acc   <= acc_n;
                count <= count + 1'b1;
            end
            if (state == FIX && !md.cancelE) begin
                md.hi <= hi_n;
                md.lo <= lo_n;
            end else if (mt_ok && md.opE == OP_MTHI) begin
                md.hi <= md.srcaE;
            end else if (mt_ok && md.opE == OP_MTLO) begin
                md.lo <= md.srcaE;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if md ();
    muldiv_unit dut (.clk(clk), .rst(rst), .md(md.slave));

    int vec = 0;
    int err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r, p;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        h = '0;
        l = '0;
        if (op == OP_MULT) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (op == OP_MULTU) begin
            up = {32'b0, a} * {32'b0, b};
            h = up[63:32];
            l = up[31:0];
        end else if (b == 0) begin
            h = a;
            l = 32'hFFFFFFFF;
        end else if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end else begin
            h = a % b;
            l = a / b;
        end
    endfunction

    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 9);
        return r == 0 ? 32'h0 : r == 1 ? 32'h80000000 : r == 2 ? 32'hFFFFFFFF : r == 3 ? 32'h1 : $urandom;
    endfunction

    task automatic idle_inputs();
        md.startE = 1'b0;
        md.opE = OP_NONE;
        md.srcaE = '0;
        md.srcbE = '0;
        md.cancelE = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [31:0] eh, el;
        n = 0;
        ref_op(op, a, b, eh, el);
        @(negedge clk);
        md.startE = 1'b1;
        md.opE = op;
        md.srcaE = a;
        md.srcbE = b;
        #1;
        while (md.stall_mdE === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            md.startE = 1'b0;
            #1;
        end
        vec++;
        if (n != 34) begin
            err++;
            $display("FAIL %s stall_cycles got %0d want 34", tag, n);
        end
        vec++;
        if (md.hi !== eh || md.lo !== el) begin
            err++;
            $display("FAIL %s result a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", tag, a, b, md.hi, md.lo, eh, el);
        end
        vec++;
        if (md.busy !== 1'b0) begin
            err++;
            $display("FAIL %s busy_in_done got %b want 0", tag, md.busy);
        end
        m_hi = eh;
        m_lo = el;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        vec++;
        if (md.hi !== 32'h0 || md.lo !== 32'h0 || md.stall_mdE !== 1'b0 || md.busy !== 1'b0) begin
            err++;
            $display("FAIL reset got hi=%h lo=%h stall=%b busy=%b want zeros", md.hi, md.lo, md.stall_mdE, md.busy);
        end
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_directed();
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        vec++;
        if (md.hi !== 32'hFFFFFFFE || md.lo !== 32'h00000001) begin
            err++;
            $display("FAIL multu_max_const got hi=%h lo=%h want hi=fffffffe lo=00000001", md.hi, md.lo);
        end
        run_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5);
        run_op("mult_min_sq", OP_MULT, 32'h80000000, 32'h80000000);
        run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0);
        run_op("div_neg_by0", OP_DIV, 32'hFFFFFFF8, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        vec++;
        if (md.hi !== 32'h0 || md.lo !== 32'h80000000) begin
            err++;
            $display("FAIL div_ovf_const got hi=%h lo=%h want hi=00000000 lo=80000000", md.hi, md.lo);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(1, 4));
            run_op("random", op, pick(), pick());
        end
    endtask

    task automatic test_mthi_mtlo();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        md.startE = 1'b1;
        md.opE = OP_MTHI;
        md.srcaE = 32'h12345678;
        #1;
        seen |= md.stall_mdE;
        @(negedge clk);
        vec++;
        if (md.hi !== 32'h12345678 || md.lo !== m_lo) begin
            err++;
            $display("FAIL mthi got hi=%h lo=%h want hi=12345678 lo=%h", md.hi, md.lo, m_lo);
        end
        md.opE = OP_MTLO;
        md.srcaE = 32'h9ABCDEF0;
        #1;
        seen |= md.stall_mdE;
        @(negedge clk);
        idle_inputs();
        vec++;
        if (md.hi !== 32'h12345678 || md.lo !== 32'h9ABCDEF0) begin
            err++;
            $display("FAIL mtlo got hi=%h lo=%h want hi=12345678 lo=9abcdef0", md.hi, md.lo);
        end
        vec++;
        if (seen !== 1'b0) begin
            err++;
            $display("FAIL mt_stall got %b want 0", seen);
        end
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_cancel();
        run_op("divu_pre", OP_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        md.startE = 1'b1;
        md.opE = OP_DIVU;
        md.srcaE = $urandom;
        md.srcbE = 32'd3;
        repeat (11) begin
            @(negedge clk);
            md.startE = 1'b0;
        end
        md.cancelE = 1'b1;
        #1;
        vec++;
        if (md.stall_mdE !== 1'b1) begin
            err++;
            $display("FAIL cancel_run_stall got %b want 1", md.stall_mdE);
        end
        @(negedge clk);
        md.cancelE = 1'b0;
        #1;
        vec++;
        if (md.stall_mdE !== 1'b0 || md.busy !== 1'b0 || md.hi !== m_hi || md.lo !== m_lo) begin
            err++;
            $display("FAIL cancel_after got stall=%b busy=%b hi=%h lo=%h want 0 0 %h %h",
                     md.stall_mdE, md.busy, md.hi, md.lo, m_hi, m_lo);
        end
        repeat (3) @(negedge clk);
        vec++;
        if (md.busy !== 1'b0 || md.hi !== m_hi || md.lo !== m_lo) begin
            err++;
            $display("FAIL cancel_hold got busy=%b hi=%h lo=%h want 0 %h %h", md.busy, md.hi, md.lo, m_hi, m_lo);
        end
        md.startE = 1'b1;
        md.opE = OP_MULT;
        md.srcaE = 32'd9;
        md.srcbE = 32'd9;
        md.cancelE = 1'b1;
        #1;
        vec++;
        if (md.stall_mdE !== 1'b0) begin
            err++;
            $display("FAIL cancel_idle_stall got %b want 0", md.stall_mdE);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vec++;
        if (md.busy !== 1'b0) begin
            err++;
            $display("FAIL cancel_idle_busy got %b want 0", md.busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom_range(2, 1000);
        ref_op(OP_MULT, a1, b1, h1, l1);
        ref_op(OP_DIVU, a2, b2, h2, l2);
        @(negedge clk);
        md.startE = 1'b1;
        md.opE = OP_MULT;
        md.srcaE = a1;
        md.srcbE = b1;
        #1;
        n = 0;
        while (md.stall_mdE === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            md.opE = OP_DIVU;
            md.srcaE = a2;
            md.srcbE = b2;
            #1;
        end
        vec++;
        if (n != 34 || md.hi !== h1 || md.lo !== l1) begin
            err++;
            $display("FAIL b2b_first got n=%0d hi=%h lo=%h want 34 %h %h", n, md.hi, md.lo, h1, l1);
        end
        @(negedge clk);
        #1;
        vec++;
        if (md.stall_mdE !== 1'b1) begin
            err++;
            $display("FAIL b2b_restart got stall=%b want 1", md.stall_mdE);
        end
        n = 0;
        while (md.stall_mdE === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            md.startE = 1'b0;
            #1;
        end
        vec++;
        if (n != 34 || md.hi !== h2 || md.lo !== l2) begin
            err++;
            $display("FAIL b2b_second got n=%0d hi=%h lo=%h want 34 %h %h", n, md.hi, md.lo, h2, l2);
        end
        idle_inputs();
        @(negedge clk);
        md.startE = 1'b1;
        md.opE = OP_MULT;
        md.srcaE = $urandom;
        md.srcbE = $urandom;
        repeat (6) begin
            @(negedge clk);
            md.startE = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        vec++;
        if (md.hi !== 32'h0 || md.lo !== 32'h0 || md.stall_mdE !== 1'b0 || md.busy !== 1'b0) begin
            err++;
            $display("FAIL rst_mid_run got hi=%h lo=%h stall=%b busy=%b want zeros", md.hi, md.lo, md.stall_mdE, md.busy);
        end
        rst = 1'b0;
        idle_inputs();
        m_hi = '0;
        m_lo = '0;
        run_op("after_rst", OP_MULTU, 32'd6, 32'd7);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_random();
        test_cancel();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage of the 5-stage MIPS pipeline. Owns the HI/LO registers.
- Drives a stall request toward the hazard unit, which freezes F/D/E while an operation runs; it is the requester end of the stall interface.
- Implements MULT, MULTU, DIV, DIVU, MTHI, MTLO. MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- DATA_W, 32, operand width. Iteration count equals DATA_W; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- startE  in  1  valid muldiv-class instruction in E (from decode control)
- opE  in  3  operation code (package constants)
- srcaE  in  32  rs operand, post-forwarding
- srcbE  in  32  rt operand, post-forwarding
- cancelE  in  1  abort in-flight operation (exception/redirect)
- stall_mdE  out  1  stall request to hazard unit; OR-ed into stallF/stallD/stallE
- busy  out  1  state is RUN or FIX
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, stall_mdE=0, busy=0. Internal counter and shift registers cleared. Reset mid-operation aborts immediately.
- States: IDLE, RUN, FIX, DONE.
- IDLE, startE with MULT/MULTU/DIV/DIVU:
  - Latch absolute values (signed ops) or raw values (unsigned ops), result sign flags, and op.
  - count=0, go to RUN.
  - stall_mdE=1 combinationally in this same cycle.
- IDLE, startE with MTHI/MTLO: hi (or lo) <= srcaE at the clock edge, no stall, stay IDLE.
- IDLE, opE NONE or startE=0: no action.
- RUN: one radix-2 step per cycle, 32 cycles (count 0..31), then FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 33-bit partial remainder, 32-bit quotient.
- FIX: apply sign correction and write hi/lo at the clock edge, then go to DONE.
  - Product negated when operand signs differ.
  - Quotient negated when signs differ; remainder takes the sign of the dividend (truncate toward zero).
- DONE: stall_mdE=0 and the pipeline advances. startE is ignored in this cycle so the completing instruction is not re-issued. Next state is IDLE.
- stall_mdE = (IDLE & startE & op in {MULT,MULTU,DIV,DIVU}) | RUN | FIX. Total stall is 34 cycles per operation.
- Divide by zero, signed or unsigned: lo=32'hFFFFFFFF, hi=srcaE raw value. The operation still takes the full 34 stall cycles.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- cancelE in RUN or FIX: return to IDLE next cycle; hi/lo unchanged; stall_mdE=0 from the next cycle. cancelE in IDLE suppresses startE.
- rst has priority over cancelE; cancelE has priority over startE.
- hi and lo change only at a FIX clock edge or on an MTHI/MTLO write.

Decomposition:
- Shared package cpu_pkg holds:
  - OP_NONE=3'd0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6
  - state encoding localparams
  - DATA_W
- Sub-module muldiv_iter: combinational single-step datapath, taking {acc, operand, mode} to the next acc (shift-add or shift-subtract). The FSM, counter, sign fixup and HI/LO registers live in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall_mdE high exactly 34 cycles starting with the start cycle; then hi=0xFFFFFFFE, lo=0x00000001; stall_mdE low in DONE.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge each, stall_mdE never asserted.
- DIVU started, cancelE pulsed at RUN cycle 10 -> IDLE next cycle, hi/lo keep prior values, stall_mdE low.
- Back-to-back: MULT then DIVU with startE held high through DONE -> DONE cycle ignored; second op starts in the following IDLE cycle; rst asserted at RUN cycle 5 -> all outputs zero next cycle.
